mem_word_responder: RTL and testbench
=====================================

Name: mem_word_responder

Overview:
- Memory-side responder for the core's load/store request port.
- Accepts one request at a time: byte, half or word; read or write; any byte address, aligned or not.
- Serves the request byte-serially from an internal byte-wide RAM, then returns one response pulse.
- Sits between the control FSM, which initiates READ_MEMORY/WRITE_MEMORY, and storage, replacing the direct combinational Ram hookup.

Parameters:
- DEPTH_BYTES, 65536, RAM size in bytes; must be a power of two; addresses wrap modulo DEPTH_BYTES.
- INIT_BYTE, 8'h00, value the RAM powers up with. The RAM is never cleared by reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_width  in  2  MemWidth: BITS8, BITS16, BITS32.
- req_signed  in  1  loads only: sign-extend (1) or zero-extend (0).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low 8, 16 or 32 bits are used.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores.
- resp_err  out  1  request rejected (feature only); otherwise tied 0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, byte index=0. RAM contents are untouched.
- States are IDLE, ACCESS and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a clock edge: latch addr, wdata, width, write and signed; clear the assembly register; set idx=0; go to ACCESS.
- ACCESS:
  - req_ready=0.
  - Each cycle touches byte address (addr+idx) mod DEPTH_BYTES. The RAM is read asynchronously.
  - Load: assembly[8*idx +: 8] <= ram byte.
  - Store: ram byte <= wdata[8*idx +: 8].
  - Little-endian.
  - When idx == nbytes-1, go to RESP; otherwise idx++. nbytes is 1, 2 or 4.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - resp_rdata = assembly, extended from 8 or 16 bits per req_signed; BITS32 passes through.
  - Next state is IDLE.
- Latency: a request accepted at edge 0 gives resp_valid high in cycle nbytes+1. Word access takes 6 cycles request-to-request.
- Back-to-back: a new request can be accepted in the first IDLE cycle after RESP. No overlap is allowed.
- Requests while busy are ignored. The initiator must hold req_valid until it sees req_ready.
- Address wrap: a word at DEPTH_BYTES-2 touches bytes DEPTH_BYTES-2, DEPTH_BYTES-1, 0 and 1.
- Reset mid-ACCESS: bytes already stored stay committed; no response is produced; the FSM returns to IDLE.
- Invalid req_width encoding (2'b11): treated as BITS32.
- resp_rdata holds its value outside RESP.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- When defined, a request is misaligned if:
  - BITS16 with addr[0]=1, or
  - BITS32 with addr[1:0]!=0.
- A misaligned request skips ACCESS and goes IDLE→RESP. In that RESP cycle: resp_valid=1, resp_err=1, resp_rdata=0, and no RAM byte is written.
- When undefined, resp_err is constant 0 and unaligned accesses proceed byte-serially as above. This is required for the core's unaligned start-address tests.

Decomposition:
- Package mem_pkg holds:
  - typedef enum logic[1:0] MemWidth {BITS8, BITS16, BITS32};
  - typedef enum logic[1:0] MemRespState {IDLE, ACCESS, RESP};
  - function nbytes(MemWidth).
- Sub-module byte_ram #(DEPTH_BYTES, INIT_BYTE):
  - Ports: clk, we, addr, wdata[7:0], rdata[7:0].
  - Asynchronous read, synchronous write.
  - Also provides a backdoor preload task for benches.

Test Plan:
- Store word 32'h12345678 at 128, then BITS32 load at 128 → resp_rdata=32'h12345678. The bench checks resp_valid is high exactly in cycle 5 after acceptance and that RAM bytes 128..131 are 78,56,34,12.
- Store word 32'h000000F0 at 200, then BITS8 load at 200 with signed=1 → 32'hFFFFFFF0. With signed=0 → 32'h000000F0. BITS16 load at 200 with signed=1 → 32'h000000F0.
- Unaligned word store of 32'hAABBCCDD at 0xFF, then load at 0xFF → 32'hAABBCCDD. Byte load at 0x100 → 32'hCC (zero-extended).
- Wrap: store 32'hDEADBEEF at DEPTH_BYTES-2 → byte 0=8'hAD, byte 1=8'hDE; reload → 32'hDEADBEEF.
- Pull rst_n low in cycle 3 of a word store of 32'h11223344 to 300 → resp_valid never pulses; bytes 300 and 301 = 44 and 33; bytes 302 and 303 unchanged; req_ready=1 the cycle after reset releases.
- With MEM_ALIGN_CHECK_EN defined: word store to 0x101 → resp_valid and resp_err pulse in cycle 1, and RAM bytes 0x101..0x104 are unchanged. With the macro undefined, the same store succeeds with resp_err=0.

Source files
------------

// File: rtl/mem_word_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared types and helpers for the byte-serial memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        BITS8  = 2'd0,
        BITS16 = 2'd1,
        BITS32 = 2'd2
    } MemWidth;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } MemRespState;

    function automatic logic [2:0] nbytes(input MemWidth w);
        case (w)
            BITS8:   return 3'd1;
            BITS16:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input MemWidth w, input logic sgn, input logic [31:0] v);
        case (w)
            BITS8:   return {{24{sgn & v[7]}}, v[7:0]};
            BITS16:  return {{16{sgn & v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    function automatic logic misaligned(input MemWidth w, input logic [1:0] a);
        case (w)
            BITS8:   return 1'b0;
            BITS16:  return a[0];
            default: return (a != 2'b00);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_word_responder_byte_ram.sv
`default_nettype none
// ============================================================================
// Module   : byte_ram
// Brief    : Byte-wide RAM, asynchronous read, synchronous write, with a
//            backdoor preload task for benches.
// Revision : 1.0 - initial release
// ============================================================================
module byte_ram #(
    parameter int         DEPTH_BYTES = 65536,
    parameter logic [7:0] INIT_BYTE   = 8'h00
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_BYTES)-1:0] addr,
    input  logic [7:0]                     wdata,
    output logic [7:0]                     rdata
);

    // Power-up contents come from the declaration; reset never clears them.
    logic [7:0] mem [DEPTH_BYTES] = '{default: INIT_BYTE};

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    task automatic preload(input logic [$clog2(DEPTH_BYTES)-1:0] a, input logic [7:0] d);
        mem[a] <= d;
    endtask

endmodule
`default_nettype wire

// File: rtl/mem_word_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_word_responder
// Brief    : Byte-serial load/store responder in front of a byte-wide RAM.
//            Define MEM_ALIGN_CHECK_EN to reject misaligned half/word requests.
// Revision : 1.0 - initial release
// ============================================================================
module mem_word_responder
    import mem_pkg::*;
#(
    parameter int         DEPTH_BYTES = 65536,
    parameter logic [7:0] INIT_BYTE   = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_width,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_BYTES);

    MemRespState   state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   asm_q, asm_d;
    logic [31:0]   rdata_q, rdata_d;
    MemWidth       width_q, width_d;
    logic          write_q, write_d;
    logic          signed_q, signed_d;
    logic [1:0]    idx_q, idx_d;

    MemWidth       req_width_w;
    logic [AW-1:0] ram_addr_w;
    logic          ram_we_w;
    logic [7:0]    ram_wdata_w;
    logic [7:0]    ram_rdata_w;
    logic [31:0]   asm_merge_w;
    logic [2:0]    last_idx_w;
    logic          last_w;
    logic          unused_addr_w;

    assign unused_addr_w = ^req_addr[31:AW];

    // The reserved width encoding behaves as a full word.
    assign req_width_w = (req_width == 2'b11) ? BITS32 : MemWidth'(req_width);

    // Address arithmetic in AW bits gives the modulo-DEPTH wrap for free.
    assign ram_addr_w  = addr_q + AW'(idx_q);
    assign ram_we_w    = (state_q == ACCESS) && write_q;
    assign ram_wdata_w = wdata_q[{idx_q, 3'b000} +: 8];
    assign last_idx_w  = nbytes(width_q) - 3'd1;
    assign last_w      = ({1'b0, idx_q} == last_idx_w);

    always_comb begin
        asm_merge_w = asm_q;
        asm_merge_w[{idx_q, 3'b000} +: 8] = ram_rdata_w;
    end

    byte_ram #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .INIT_BYTE   (INIT_BYTE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_w),
        .addr  (ram_addr_w),
        .wdata (ram_wdata_w),
        .rdata (ram_rdata_w)
    );

`ifdef MEM_ALIGN_CHECK_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        asm_d    = asm_q;
        rdata_d  = rdata_q;
        width_d  = width_q;
        write_d  = write_q;
        signed_d = signed_q;
        idx_d    = idx_q;
`ifdef MEM_ALIGN_CHECK_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr[AW-1:0];
                    wdata_d  = req_wdata;
                    width_d  = req_width_w;
                    write_d  = req_write;
                    signed_d = req_signed;
                    asm_d    = 32'h0;
                    idx_d    = 2'd0;
                    state_d  = ACCESS;
`ifdef MEM_ALIGN_CHECK_EN
                    if (misaligned(req_width_w, req_addr[1:0])) begin
                        state_d = RESP;
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            ACCESS: begin
                if (!write_q) begin
                    asm_d = asm_merge_w;
                end
                if (last_w) begin
                    state_d = RESP;
                    rdata_d = write_q ? 32'h0 : extend(width_q, signed_q, asm_merge_w);
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
`ifdef MEM_ALIGN_CHECK_EN
                err_d   = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            asm_q    <= 32'h0;
            rdata_q  <= 32'h0;
            width_q  <= BITS8;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            idx_q    <= 2'd0;
`ifdef MEM_ALIGN_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            asm_q    <= asm_d;
            rdata_q  <= rdata_d;
            width_q  <= width_d;
            write_q  <= write_d;
            signed_q <= signed_d;
            idx_q    <= idx_d;
`ifdef MEM_ALIGN_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign resp_err   = err_q;
`else
    assign resp_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_word_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_word_responder
// Brief    : Directed self-checking bench for mem_word_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_word_responder;

    localparam int DEPTH = 65536;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_width = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] r_rd;
    int          r_lat;
    int          r_pul;
    logic        r_err;
    logic        r_rdy;

    mem_word_responder #(
        .DEPTH_BYTES (DEPTH),
        .INIT_BYTE   (8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_width  (req_width),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Issue one request and watch 10 cycles; latency counts cycles after the accepting edge.
    task automatic do_req(input logic wr, input logic [1:0] w, input logic sg,
                          input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        r_rdy      = req_ready;
        req_write  = wr;
        req_width  = w;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = d;
        req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        r_lat = 0;
        r_pul = 0;
        r_rd  = 'x;
        r_err = 1'bx;
        for (int n = 1; n <= 10; n++) begin
            if (n > 1) @(negedge clk);
            if (resp_valid === 1'b1) begin
                r_pul++;
                if (r_lat == 0) begin
                    r_lat = n;
                    r_rd  = resp_rdata;
                    r_err = resp_err;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", req_ready); end
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", resp_valid); end
        n_tests++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h exp 0", resp_rdata); end
        n_tests++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b exp 0", resp_err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    endtask

    task automatic test_word();
        do_req(1'b1, 2'd2, 1'b0, 32'd128, 32'h12345678);
        n_tests++; if (r_rdy !== 1'b1) begin n_fail++; $display("FAIL word_st_ready: got %b exp 1", r_rdy); end
        n_tests++; if (r_lat !== 5 || r_pul !== 1) begin n_fail++; $display("FAIL word_st_lat: got lat %0d pulses %0d exp lat 5 pulses 1", r_lat, r_pul); end
        n_tests++; if (r_rd !== 32'h0 || r_err !== 1'b0) begin n_fail++; $display("FAIL word_st_resp: got %h err %b exp 0 err 0", r_rd, r_err); end
        n_tests++;
        if ({dut.u_ram.mem[131], dut.u_ram.mem[130], dut.u_ram.mem[129], dut.u_ram.mem[128]} !== 32'h12345678) begin
            n_fail++;
            $display("FAIL word_st_bytes: got %h %h %h %h exp 78 56 34 12", dut.u_ram.mem[128], dut.u_ram.mem[129], dut.u_ram.mem[130], dut.u_ram.mem[131]);
        end
        do_req(1'b0, 2'd2, 1'b0, 32'd128, 32'h0);
        n_tests++; if (r_lat !== 5 || r_pul !== 1) begin n_fail++; $display("FAIL word_ld_lat: got lat %0d pulses %0d exp lat 5 pulses 1", r_lat, r_pul); end
        n_tests++; if (r_rd !== 32'h12345678) begin n_fail++; $display("FAIL word_ld_data: got %h exp 12345678", r_rd); end
        n_tests++; if (resp_rdata !== 32'h12345678) begin n_fail++; $display("FAIL word_ld_hold: got %h exp 12345678", resp_rdata); end
    endtask

    task automatic test_sign();
        do_req(1'b1, 2'd2, 1'b0, 32'd200, 32'h000000F0);
        do_req(1'b0, 2'd0, 1'b1, 32'd200, 32'h0);
        n_tests++; if (r_lat !== 2 || r_rd !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL byte_signed: got %h lat %0d exp FFFFFFF0 lat 2", r_rd, r_lat); end
        do_req(1'b0, 2'd0, 1'b0, 32'd200, 32'h0);
        n_tests++; if (r_rd !== 32'h000000F0) begin n_fail++; $display("FAIL byte_unsigned: got %h exp 000000F0", r_rd); end
        do_req(1'b0, 2'd1, 1'b1, 32'd200, 32'h0);
        n_tests++; if (r_lat !== 3 || r_rd !== 32'h000000F0) begin n_fail++; $display("FAIL half_signed: got %h lat %0d exp 000000F0 lat 3", r_rd, r_lat); end
        do_req(1'b1, 2'd1, 1'b0, 32'd204, 32'h0000_8001);
        do_req(1'b0, 2'd1, 1'b1, 32'd204, 32'h0);
        n_tests++; if (r_rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL half_neg: got %h exp FFFF8001", r_rd); end
    endtask

    task automatic test_invalid_width();
        do_req(1'b0, 2'd3, 1'b1, 32'd128, 32'h0);
        n_tests++; if (r_lat !== 5 || r_rd !== 32'h12345678) begin n_fail++; $display("FAIL width3_load: got %h lat %0d exp 12345678 lat 5", r_rd, r_lat); end
    endtask

    task automatic test_unaligned();
        do_req(1'b1, 2'd2, 1'b0, 32'h0FF, 32'hAABBCCDD);
`ifdef MEM_ALIGN_CHECK_EN
        n_tests++; if (r_lat !== 1 || r_err !== 1'b1) begin n_fail++; $display("FAIL unal_reject: got lat %0d err %b exp lat 1 err 1", r_lat, r_err); end
`else
        n_tests++; if (r_lat !== 5 || r_err !== 1'b0) begin n_fail++; $display("FAIL unal_store: got lat %0d err %b exp lat 5 err 0", r_lat, r_err); end
        do_req(1'b0, 2'd2, 1'b0, 32'h0FF, 32'h0);
        n_tests++; if (r_rd !== 32'hAABBCCDD) begin n_fail++; $display("FAIL unal_load: got %h exp AABBCCDD", r_rd); end
        do_req(1'b0, 2'd0, 1'b0, 32'h100, 32'h0);
        n_tests++; if (r_rd !== 32'h000000CC) begin n_fail++; $display("FAIL unal_byte: got %h exp 000000CC", r_rd); end
`endif
    endtask

    task automatic test_wrap();
        do_req(1'b1, 2'd2, 1'b0, DEPTH - 2, 32'hDEADBEEF);
`ifdef MEM_ALIGN_CHECK_EN
        n_tests++; if (r_err !== 1'b1) begin n_fail++; $display("FAIL wrap_reject: got err %b exp 1", r_err); end
`else
        n_tests++; if (dut.u_ram.mem[0] !== 8'hAD || dut.u_ram.mem[1] !== 8'hDE) begin n_fail++; $display("FAIL wrap_bytes: got %h %h exp AD DE", dut.u_ram.mem[0], dut.u_ram.mem[1]); end
        n_tests++; if (dut.u_ram.mem[DEPTH-2] !== 8'hEF || dut.u_ram.mem[DEPTH-1] !== 8'hBE) begin n_fail++; $display("FAIL wrap_top: got %h %h exp EF BE", dut.u_ram.mem[DEPTH-2], dut.u_ram.mem[DEPTH-1]); end
        do_req(1'b0, 2'd2, 1'b0, DEPTH - 2, 32'h0);
        n_tests++; if (r_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wrap_load: got %h exp DEADBEEF", r_rd); end
`endif
    endtask

    task automatic test_reset_mid();
        int pulses;
        do_req(1'b1, 2'd0, 1'b0, 32'd302, 32'h5A);
        do_req(1'b1, 2'd0, 1'b0, 32'd303, 32'hA5);
        pulses = 0;
        @(negedge clk);
        req_write = 1'b1; req_width = 2'd2; req_addr = 32'd300; req_wdata = 32'h11223344; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid === 1'b1) pulses++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got ready %b busy %b exp 1 0", req_ready, busy); end
        repeat (6) begin
            if (resp_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL rstmid_nopulse: got %0d pulses exp 0", pulses); end
        n_tests++;
        if (dut.u_ram.mem[300] !== 8'h44 || dut.u_ram.mem[301] !== 8'h33 || dut.u_ram.mem[302] !== 8'h5A || dut.u_ram.mem[303] !== 8'hA5) begin
            n_fail++;
            $display("FAIL rstmid_bytes: got %h %h %h %h exp 44 33 5A A5", dut.u_ram.mem[300], dut.u_ram.mem[301], dut.u_ram.mem[302], dut.u_ram.mem[303]);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_write = 1'b1; req_width = 2'd0; req_signed = 1'b0; req_addr = 32'd400; req_wdata = 32'h5A; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Second request presented while busy; it must wait for the IDLE cycle.
        req_write = 1'b0; req_addr = 32'd400; req_wdata = 32'h0;
        n_tests++; if (req_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got ready %b busy %b exp 0 1", req_ready, busy); end
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_resp1: got valid %b ready %b exp 1 0", resp_valid, req_ready); end
        @(negedge clk);
        n_tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got ready %b valid %b exp 1 0", req_ready, resp_valid); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept2: got busy %b exp 1", busy); end
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h5A) begin n_fail++; $display("FAIL b2b_resp2: got valid %b data %h exp 1 0000005A", resp_valid, resp_rdata); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_align();
        do_req(1'b1, 2'd0, 1'b0, 32'h101, 32'h11);
        do_req(1'b1, 2'd0, 1'b0, 32'h102, 32'h22);
        do_req(1'b1, 2'd0, 1'b0, 32'h103, 32'h33);
        do_req(1'b1, 2'd0, 1'b0, 32'h104, 32'h44);
        do_req(1'b1, 2'd2, 1'b0, 32'h101, 32'h01020304);
`ifdef MEM_ALIGN_CHECK_EN
        n_tests++; if (r_lat !== 1 || r_pul !== 1 || r_err !== 1'b1 || r_rd !== 32'h0) begin n_fail++; $display("FAIL align_err: got lat %0d pulses %0d err %b data %h exp 1 1 1 0", r_lat, r_pul, r_err, r_rd); end
        n_tests++;
        if ({dut.u_ram.mem[32'h104], dut.u_ram.mem[32'h103], dut.u_ram.mem[32'h102], dut.u_ram.mem[32'h101]} !== 32'h44332211) begin
            n_fail++; $display("FAIL align_untouched: got %h %h %h %h exp 11 22 33 44", dut.u_ram.mem[32'h101], dut.u_ram.mem[32'h102], dut.u_ram.mem[32'h103], dut.u_ram.mem[32'h104]);
        end
        n_tests++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL align_err_clear: got %b exp 0", resp_err); end
`else
        n_tests++; if (r_lat !== 5 || r_err !== 1'b0) begin n_fail++; $display("FAIL align_ok: got lat %0d err %b exp lat 5 err 0", r_lat, r_err); end
        n_tests++;
        if ({dut.u_ram.mem[32'h104], dut.u_ram.mem[32'h103], dut.u_ram.mem[32'h102], dut.u_ram.mem[32'h101]} !== 32'h01020304) begin
            n_fail++; $display("FAIL align_bytes: got %h %h %h %h exp 04 03 02 01", dut.u_ram.mem[32'h101], dut.u_ram.mem[32'h102], dut.u_ram.mem[32'h103], dut.u_ram.mem[32'h104]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_word();
        test_sign();
        test_invalid_width();
        test_unaligned();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_align();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, exp finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
